// File: rtl/pipe_pkg.sv
// Shared fetch-pipeline definitions: default widths, PC step,
// NOP encoding and the prefetch FSM state encoding.
package pipe_pkg;
   localparam int ADDR_W_DEF  = 32;
   localparam int DATA_W_DEF  = 32;
   localparam int PC_STEP_DEF = 4;
   localparam logic [31:0] NOP = 32'h0;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } fetch_state_e;

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with push/pop/clear and occupancy count.
// Clear keeps the head slot so the read data holds its last value.
module sync_fifo
   import pipe_pkg::*;
#(
   parameter int W     = 64,
   parameter int DEPTH = 4,
   localparam int CW   = cnt_w(DEPTH),
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic [W-1:0]  data_i,
   input  logic          pop_i,
   input  logic          clear_i,
   output logic [W-1:0]  data_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] count_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else if (clear_i) begin
         wr_q    <= rd_q;
         count_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= wr_q + AW'(1);
         end
         if (pop_i) rd_q <= rd_q + AW'(1);
         count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   assign data_o  = mem_q[rd_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: credit-limited fetch, in-order responses,
// redirect flush with discard of responses still in flight.
module if_prefetch_queue
   import pipe_pkg::*;
#(
   parameter int ADDR_W                = ADDR_W_DEF,
   parameter int DATA_W                = DATA_W_DEF,
   parameter int DEPTH                 = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int PC_STEP               = PC_STEP_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [DATA_W-1:0] id_ir,
   output logic [ADDR_W-1:0] id_npc
);
   localparam int CW = cnt_w(DEPTH);
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, rpc_q, rpc_d;
   logic [CW-1:0]     infl_q, infl_d, disc_q, disc_d;

   logic [CW-1:0]     count;
   logic [CW:0]       occ;
   logic              push, pop, full, empty;
   logic [DATA_W+ADDR_W-1:0] head;

   always_comb begin
      occ      = {1'b0, count} + {1'b0, infl_q};
      imem_req = (state_q != BOOT) && !redirect && (occ < DEPTH_C);
      push     = 1'b0;
      pop      = id_valid && id_ready && !redirect;
      pc_d     = pc_q;
      rpc_d    = rpc_q;
      infl_d   = infl_q;
      disc_d   = disc_q;
      if (redirect) begin
         // Everything still outstanding belongs to the old path.
         disc_d = infl_q - CW'(imem_rvalid);
         infl_d = infl_q - CW'(imem_rvalid);
         pc_d   = redirect_pc;
         rpc_d  = redirect_pc;
      end else begin
         infl_d = infl_q + CW'(imem_req) - CW'(imem_rvalid);
         if (imem_req) pc_d = pc_q + STEP;
         if (imem_rvalid) begin
            if (disc_q != '0) begin
               disc_d = disc_q - CW'(1);
            end else begin
               push  = 1'b1;
               rpc_d = rpc_q + STEP;
            end
         end
      end
      state_d = state_q;
      if (state_q == BOOT)
         state_d = RUN;
      else if (redirect)
         state_d = (disc_d != '0) ? FLUSH : RUN;
      else if (state_q == FLUSH && disc_d == '0)
         state_d = RUN;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         rpc_q   <= RESET_PC;
         infl_q  <= '0;
         disc_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         rpc_q   <= rpc_d;
         infl_q  <= infl_d;
         disc_q  <= disc_d;
      end
   end

   sync_fifo #(
      .W     (DATA_W + ADDR_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .data_i  ({imem_rdata, rpc_q + STEP}),
      .pop_i   (pop),
      .clear_i (redirect),
      .data_o  (head),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
   );

   assign imem_addr = pc_q;
   assign id_valid  = !empty;
   assign id_ir     = head[ADDR_W +: DATA_W];
   assign id_npc    = head[ADDR_W-1:0];

   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (occ <= DEPTH_C);
         assert (!(push && full));
      end
   end
endmodule
